// File: rtl/ic_bank_req_buffer_if.sv
// Request bus between the I-cache arbitration tree, the bank request buffer and one cache bank.
// Carries the upstream req/gnt handshake and the downstream bank req/gnt/r_valid signals.
// The slave modport is the buffer's view. The master modport is the driver and monitor view.
interface ic_bank_req_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 20
);

  // upstream side (arbitration tree -> buffer)
  logic                  data_req_i;
  logic [ADDR_WIDTH-1:0] data_add_i;
  logic [ID_WIDTH-1:0]   data_ID_i;
  logic                  data_gnt_o;

  // downstream side (buffer -> cache bank)
  logic                  data_req_o;
  logic [ADDR_WIDTH-1:0] data_add_o;
  logic [ID_WIDTH-1:0]   data_ID_o;
  logic                  data_gnt_i;
  logic                  data_r_valid_i;

  modport slave (
    input  data_req_i,
    input  data_add_i,
    input  data_ID_i,
    output data_gnt_o,
    output data_req_o,
    output data_add_o,
    output data_ID_o,
    input  data_gnt_i,
    input  data_r_valid_i
  );

  modport master (
    output data_req_i,
    output data_add_i,
    output data_ID_i,
    input  data_gnt_o,
    input  data_req_o,
    input  data_add_o,
    input  data_ID_o,
    output data_gnt_i,
    output data_r_valid_i
  );

endinterface

// File: rtl/ic_bank_req_buffer.sv
// Elastic in-order request buffer between the I-cache arbitration tree and one cache bank.
// Latency: 1 cycle from an accepted push to data_req_o. There is no bypass path.
// Backpressure: data_gnt_o = FIFO not full, from local state only. data_req_o is held off at MAX_OUTSTANDING.
module ic_bank_req_buffer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 20,
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  ic_bank_req_buffer_if.slave                    bus,
  output logic                                   empty_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  // one buffered request: address and requester ID, both passed through untouched
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic [ID_WIDTH-1:0]   id;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [OUT_W-1:0]  outstanding;
  logic              err;

  logic              gnt_up;
  logic              req_dn;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            head;

  // The upstream grant reflects only registered occupancy. This breaks the
  // combinational path from the bank grant back into the arbitration tree.
  assign gnt_up = (count != CNT_FULL);

  // Issue only with a buffered entry and room under the outstanding cap.
  assign req_dn = (count != '0) && (outstanding < OUT_MAX);

  assign push = bus.data_req_i && gnt_up;
  assign pop  = req_dn && bus.data_gnt_i;

  assign wr_entry.add = bus.data_add_i;
  assign wr_entry.id  = bus.data_ID_i;
  assign head         = mem[rd_ptr];

  assign bus.data_gnt_o = gnt_up;
  assign bus.data_req_o = req_dn;
  assign bus.data_add_o = head.add;
  assign bus.data_ID_o  = head.id;

  assign empty_o       = (count == '0);
  assign outstanding_o = outstanding;
  assign err_o         = err;

  // Entry storage. It is cleared on reset so the head outputs read as zero while idle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Write and read pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy. A simultaneous push and pop leaves it unchanged at every fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outstanding bank requests. A stray response saturates at zero and latches the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      case ({pop, bus.data_r_valid_i})
        2'b10: outstanding <= outstanding + 1'b1;
        2'b01: begin
          if (outstanding == '0) begin
            err <= 1'b1;
          end else begin
            outstanding <= outstanding - 1'b1;
          end
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_ic_bank_req_buffer.sv
// Directed and random checks of ic_bank_req_buffer against a queue-based reference model.
// The model tracks buffered entries, the outstanding count and the sticky error flag.
// Outputs are sampled on the falling edge. Inputs change on the falling edge.
module tb_ic_bank_req_buffer;

  localparam int AW    = 32;
  localparam int IW    = 20;
  localparam int DEPTH = 2;
  localparam int MAXO  = 4;
  localparam int OW    = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          empty;
  logic [OW-1:0] outst;
  logic          err;

  ic_bank_req_buffer_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  ic_bank_req_buffer #(
    .ADDR_WIDTH(AW),
    .ID_WIDTH(IW),
    .DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .empty_o(empty),
    .outstanding_o(outst),
    .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [IW-1:0] id;
  } ent_t;

  int            tests = 0;
  int            fails = 0;
  ent_t          mq[$];
  int            m_out = 0;
  bit            m_err = 1'b0;
  logic [AW-1:0] issued[$];

  task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model state implies.
  task automatic check_model(input string tag);
    chk(tag, "gnt_o", 64'(bus.data_gnt_o), 64'(mq.size() < DEPTH));
    chk(tag, "req_o", 64'(bus.data_req_o), 64'(mq.size() > 0 && m_out < MAXO));
    chk(tag, "empty", 64'(empty), 64'(mq.size() == 0));
    chk(tag, "outstanding", 64'(outst), 64'(m_out));
    chk(tag, "err", 64'(err), 64'(m_err));
    if (mq.size() > 0) begin
      chk(tag, "add_o", 64'(bus.data_add_o), 64'(mq[0].a));
      chk(tag, "ID_o", 64'(bus.data_ID_o), 64'(mq[0].id));
    end
  endtask

  task automatic reset_values(input string tag);
    chk(tag, "gnt_o", 64'(bus.data_gnt_o), 64'd1);
    chk(tag, "req_o", 64'(bus.data_req_o), 64'd0);
    chk(tag, "add_o", 64'(bus.data_add_o), 64'd0);
    chk(tag, "ID_o", 64'(bus.data_ID_o), 64'd0);
    chk(tag, "empty", 64'(empty), 64'd1);
    chk(tag, "outstanding", 64'(outst), 64'd0);
    chk(tag, "err", 64'(err), 64'd0);
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model at the rising edge, check at the next falling edge.
  task automatic step(input string tag, input logic req, input logic [AW-1:0] a, input logic [IW-1:0] id,
                      input logic bg, input logic rv, output bit popped);
    bit do_push;
    bit do_pop;
    ent_t e;
    bus.data_req_i     = req;
    bus.data_add_i     = a;
    bus.data_ID_i      = id;
    bus.data_gnt_i     = bg;
    bus.data_r_valid_i = rv;
    do_push = req && (mq.size() < DEPTH);
    do_pop  = bg && (mq.size() > 0) && (m_out < MAXO);
    if (do_pop) issued.push_back(bus.data_add_o);
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.a  = a;
      e.id = id;
      mq.push_back(e);
    end
    if (do_pop && !rv) m_out++;
    else if (rv && !do_pop) begin
      if (m_out == 0) m_err = 1'b1;
      else m_out--;
    end
    popped = do_pop;
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle_inputs();
    bus.data_req_i     = 1'b0;
    bus.data_add_i     = '0;
    bus.data_ID_i      = '0;
    bus.data_gnt_i     = 1'b0;
    bus.data_r_valid_i = 1'b0;
  endtask

  // Reset asserted partway through a cycle. Outputs are checked before the next clock edge.
  task automatic mid_reset(input string tag);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1 reset_values(tag);
    mq.delete();
    m_out = 0;
    m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit p;
    bit prev_pop;
    logic [AW-1:0] exp_ord[$];

    idle_inputs();
    rst_n = 1'b0;
    #1 reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reset_values("reset_release");

    // single transfer
    step("single_push", 1'b1, 32'h100, 20'h3, 1'b1, 1'b0, p);
    chk("single", "req_o", 64'(bus.data_req_o), 64'd1);
    chk("single", "add_o", 64'(bus.data_add_o), 64'h100);
    chk("single", "ID_o", 64'(bus.data_ID_o), 64'h3);
    step("single_pop", 1'b0, '0, '0, 1'b1, 1'b0, p);
    chk("single", "outst_after_pop", 64'(outst), 64'd1);
    step("single_resp", 1'b0, '0, '0, 1'b0, 1'b1, p);
    chk("single", "outst_after_resp", 64'(outst), 64'd0);
    chk("single", "err_after_resp", 64'(err), 64'd0);

    // fill and backpressure
    issued.delete();
    step("fill1", 1'b1, 32'h10, 20'h1, 1'b0, 1'b0, p);
    step("fill2", 1'b1, 32'h20, 20'h2, 1'b0, 1'b0, p);
    chk("fill", "gnt_o_full", 64'(bus.data_gnt_o), 64'd0);
    step("fill_hold", 1'b1, 32'h30, 20'h3, 1'b0, 1'b0, p);
    chk("fill", "head_kept", 64'(bus.data_add_o), 64'h10);
    step("fill_drain1", 1'b1, 32'h30, 20'h3, 1'b1, 1'b0, p);
    step("fill_drain2", 1'b1, 32'h30, 20'h3, 1'b1, 1'b0, p);
    step("fill_drain3", 1'b0, '0, '0, 1'b1, 1'b0, p);
    exp_ord = '{32'h10, 32'h20, 32'h30};
    chk("fill", "issue_count", 64'(issued.size()), 64'd3);
    for (int i = 0; i < 3 && i < issued.size(); i++) chk("fill", "order", 64'(issued[i]), 64'(exp_ord[i]));
    repeat (3) step("fill_resp", 1'b0, '0, '0, 1'b0, 1'b1, p);
    chk("fill", "outst_drained", 64'(outst), 64'd0);

    // streaming
    issued.delete();
    prev_pop = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step("stream", (i < 16), 32'h1000 + 32'(i), 20'(i), 1'b1, prev_pop, p);
      prev_pop = p;
      chk("stream", "gnt_o_high", 64'(bus.data_gnt_o), 64'd1);
      chk("stream", "outst_le1", 64'(outst <= 1), 64'd1);
    end
    if (prev_pop) step("stream_tail", 1'b0, '0, '0, 1'b0, 1'b1, p);
    chk("stream", "issue_count", 64'(issued.size()), 64'd16);
    for (int i = 0; i < 16 && i < issued.size(); i++)
      chk("stream", "order", 64'(issued[i]), 64'(32'h1000 + 32'(i)));

    // outstanding cap
    issued.delete();
    for (int i = 0; i < 6; i++) step("cap_push", 1'b1, 32'h2000 + 32'(i), 20'(i), 1'b1, 1'b0, p);
    repeat (4) step("cap_idle", 1'b0, '0, '0, 1'b1, 1'b0, p);
    chk("cap", "pops", 64'(issued.size()), 64'd4);
    chk("cap", "req_o_low", 64'(bus.data_req_o), 64'd0);
    chk("cap", "outst_max", 64'(outst), 64'd4);
    chk("cap", "full", 64'(bus.data_gnt_o), 64'd0);
    step("cap_resp", 1'b0, '0, '0, 1'b1, 1'b1, p);
    repeat (3) step("cap_after", 1'b0, '0, '0, 1'b1, 1'b0, p);
    chk("cap", "one_more_pop", 64'(issued.size()), 64'd5);
    chk("cap", "fifth_addr", 64'(issued[issued.size()-1]), 64'h2004);

    // simultaneous push, pop and response at count 1, outstanding 1
    mid_reset("reset_simul");
    step("simul_a", 1'b1, 32'hA0, 20'hA, 1'b0, 1'b0, p);
    step("simul_b", 1'b1, 32'hB0, 20'hB, 1'b1, 1'b0, p);
    chk("simul", "outst_pre", 64'(outst), 64'd1);
    step("simul_c", 1'b1, 32'hC0, 20'hC, 1'b1, 1'b1, p);
    chk("simul", "outst", 64'(outst), 64'd1);
    chk("simul", "head_add", 64'(bus.data_add_o), 64'hC0);
    chk("simul", "head_id", 64'(bus.data_ID_o), 64'hC);
    chk("simul", "not_full", 64'(bus.data_gnt_o), 64'd1);
    chk("simul", "not_empty", 64'(empty), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic rv;
      rv = (m_out > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      step("random", 1'($urandom_range(0, 1)), $urandom, 20'($urandom), 1'($urandom_range(0, 1)), rv, p);
    end

    // error after mid-run reset
    mid_reset("reset_err_prep");
    for (int i = 0; i < 4; i++) step("err_fill", 1'b1, 32'h300 + 32'(i), 20'(i), 1'b1, 1'b0, p);
    step("err_fill", 1'b1, 32'h304, 20'h4, 1'b0, 1'b0, p);
    chk("err", "outst_pre", 64'(outst), 64'd3);
    chk("err", "full_pre", 64'(bus.data_gnt_o), 64'd0);
    mid_reset("reset_mid_run");
    step("err_resp", 1'b0, '0, '0, 1'b0, 1'b1, p);
    chk("err", "err_set", 64'(err), 64'd1);
    chk("err", "outst_zero", 64'(outst), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
